// File: rtl/mdu_rv32m_if.sv
// Operand/result bundle between the rv32i core and the RV32M multiply/divide unit.
interface mdu_rv32m_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, funct3, op_a, op_b, rd_in,
        input  busy, valid, result, rd_out
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in,
        output busy, valid, result, rd_out
    );
endinterface

// File: rtl/mdu_rv32m.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional macro MDU_FAST_MUL_EN: single-cycle combinational multiplier for MUL/MULH/MULHSU/MULHU.
module mdu_rv32m #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    mdu_rv32m_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opd_q, opd_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_q, rd_d;

    logic            is_div, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, fast_div_res;

    always_comb begin
        is_div       = bus.funct3[2];
        sgn_a        = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
        sgn_b        = is_div ? ~bus.funct3[0] : ~bus.funct3[1];
        a_neg        = sgn_a & bus.op_a[XLEN-1];
        b_neg        = sgn_b & bus.op_b[XLEN-1];
        a_mag        = a_neg ? -bus.op_a : bus.op_a;
        b_mag        = b_neg ? -bus.op_b : bus.op_b;
        div_zero     = is_div && (bus.op_b == '0);
        div_ovf      = is_div && ~bus.funct3[0] && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
        fast_div_res = div_zero ? (bus.funct3[1] ? bus.op_a : '1)
                                : (bus.funct3[1] ? '0 : MIN_NEG);
    end

    // acc holds the product high half / partial remainder; lo holds the multiplier / quotient
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   acc_step, lo_step, quo_fin, rem_fin, calc_res;
    logic [2*XLEN-1:0] prod_raw, prod_fin;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        div_shift = {acc_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opd_q};
        div_ge    = ~div_diff[XLEN];
        if (op_q[2]) begin
            acc_step = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_step  = {lo_q[XLEN-2:0], div_ge};
        end else begin
            acc_step = mul_sum[XLEN:1];
            lo_step  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod_raw = {acc_step, lo_step};
        prod_fin = neg_q ? -prod_raw : prod_raw;
        quo_fin  = neg_q ? -lo_step : lo_step;
        rem_fin  = neg_q ? -acc_step : acc_step;
        if (op_q[2]) begin
            calc_res = op_q[1] ? rem_fin : quo_fin;
        end else begin
            calc_res = (op_q[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
        end
    end

`ifdef MDU_FAST_MUL_EN
    // Sign-extended 2*XLEN product equals the 33x33 signed product modulo 2^(2*XLEN)
    logic [2*XLEN-1:0] fmul_a, fmul_b, fmul_p;
    logic [XLEN-1:0]   fmul_res;

    always_comb begin
        fmul_a   = {{XLEN{a_neg}}, bus.op_a};
        fmul_b   = {{XLEN{b_neg}}, bus.op_b};
        fmul_p   = fmul_a * fmul_b;
        fmul_res = (bus.funct3[1:0] == 2'b00) ? fmul_p[XLEN-1:0] : fmul_p[2*XLEN-1:XLEN];
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opd_d    = opd_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        result_d = result_q;
        rd_d     = rd_q;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    op_d   = bus.funct3;
                    rd_d   = bus.rd_in;
                    neg_d  = (is_div && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
                    acc_d  = '0;
                    busy_d = 1'b1;
                    if (div_zero || div_ovf) begin
                        result_d = fast_div_res;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
`ifdef MDU_FAST_MUL_EN
                    end else if (!is_div) begin
                        result_d = fmul_res;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
`endif
                    end else begin
                        cnt_d   = 5'd31;
                        lo_d    = is_div ? a_mag : b_mag;
                        opd_d   = is_div ? b_mag : a_mag;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_step;
                lo_d  = lo_step;
                if (cnt_q == 5'd0) begin
                    result_d = calc_res;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            opd_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opd_q    <= opd_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.valid  = valid_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_q;
endmodule

// File: tb/tb_mdu_rv32m.sv
// Directed-vector bench for mdu_rv32m: table of RV32M ops plus hand-written timing corner cases.
module tb_mdu_rv32m;
    logic clk;
    logic rst;

    mdu_rv32m_if #(.XLEN(32)) bus ();

    mdu_rv32m #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_start(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
    endtask

    // Issue one op, find the cycle valid rises (k cycles after accept), check result and pulse width.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat);
        int k;
        @(negedge clk);
        drive_start(f3, a, b, rd);
        @(posedge clk);
        #1 bus.start = 1'b0;
        k = 41;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) check({name, " busy"}, 32'(bus.busy), 32'd1);
            if (bus.valid) begin
                k = c;
                break;
            end
        end
        check({name, " latency"}, 32'(k), 32'(lat));
        check({name, " result"}, bus.result, exp);
        check({name, " rd_out"}, 32'(bus.rd_out), 32'(rd));
        @(negedge clk);
        check({name, " valid pulse"}, 32'(bus.valid), 32'd0);
    endtask

    initial begin
        int k;
        int seen;

        vecs[0]  = '{3'b000, 32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, MUL_LAT};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, MUL_LAT};
        vecs[2]  = '{3'b011, 32'h80000000, 32'h80000000, 5'd7,  32'h40000000, MUL_LAT};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, MUL_LAT};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, DIV_LAT};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, DIV_LAT};
        vecs[6]  = '{3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       DIV_LAT};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        DIV_LAT};
        vecs[8]  = '{3'b101, 32'h00001234, 32'd0,        5'd13, 32'hFFFFFFFF, 1};
        vecs[9]  = '{3'b111, 32'h00001234, 32'd0,        5'd14, 32'h00001234, 1};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1};
        vecs[12] = '{3'b100, 32'd5,        32'd0,        5'd17, 32'hFFFFFFFF, 1};
        vecs[13] = '{3'b110, 32'hFFFFFFF7, 32'd0,        5'd18, 32'hFFFFFFF7, 1};
        vecs[14] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd19, 32'd0,        MUL_LAT};
        vecs[15] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, 32'hFFFFFFFE, MUL_LAT};
        vecs[16] = '{3'b100, 32'd7,        32'hFFFFFFFE, 5'd21, 32'hFFFFFFFD, DIV_LAT};
        vecs[17] = '{3'b110, 32'd7,        32'hFFFFFFFE, 5'd22, 32'd1,        DIV_LAT};
        vecs[18] = '{3'b101, 32'hFFFFFFFF, 32'd1,        5'd23, 32'hFFFFFFFF, DIV_LAT};
        vecs[19] = '{3'b111, 32'h80000000, 32'd3,        5'd24, 32'd2,        DIV_LAT};
        vecs[20] = '{3'b000, 32'h12345678, 32'h00000010, 5'd0,  32'h23456780, MUL_LAT};
        vecs[21] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd25, 32'd0,        DIV_LAT};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.rd_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy",   32'(bus.busy),   32'd0);
        check("reset valid",  32'(bus.valid),  32'd0);
        check("reset result", bus.result,      32'd0);
        check("reset rd_out", 32'(bus.rd_out), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                   vecs[i].rd, vecs[i].exp, vecs[i].lat);
        end

        // Second start during CALC is ignored; a start during the valid cycle is ignored too.
        @(negedge clk);
        drive_start(3'b101, 32'd1000, 32'd10, 5'd3);
        @(posedge clk);
        #1 bus.start = 1'b0;
        k = 41;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 5) drive_start(3'b000, 32'd3, 32'd3, 5'd9);
            if (c == 6) bus.start = 1'b0;
            if (bus.valid) begin
                k = c;
                break;
            end
        end
        check("ignore latency", 32'(k), 32'd33);
        check("ignore result",  bus.result, 32'd100);
        check("ignore rd_out",  32'(bus.rd_out), 32'd3);
        drive_start(3'b000, 32'd3, 32'd3, 5'd9);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("done start busy",  32'(bus.busy),  32'd0);
        check("done start valid", 32'(bus.valid), 32'd0);
        check("done start held",  bus.result,     32'd100);

        // Reset in the middle of a divide discards it.
        @(negedge clk);
        drive_start(3'b100, 32'hFFFFFFF9, 32'd2, 5'd7);
        @(posedge clk);
        #1 bus.start = 1'b0;
        seen = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.valid) seen++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst busy",   32'(bus.busy),   32'd0);
        check("midrst result", bus.result,      32'd0);
        check("midrst rd_out", 32'(bus.rd_out), 32'd0);
        for (int c = 12; c <= 40; c++) begin
            @(negedge clk);
            if (bus.valid) seen++;
        end
        check("midrst no valid", 32'(seen), 32'd0);
        run_op("post rst", 3'b101, 32'd100, 32'd7, 5'd4, 32'd14, DIV_LAT);

        // Reset and start in the same cycle: reset wins.
        @(negedge clk);
        drive_start(3'b101, 32'd50, 32'd5, 5'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        check("rst+start busy",   32'(bus.busy),   32'd0);
        check("rst+start rd_out", 32'(bus.rd_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_rv32m.md
# mdu_rv32m

Iterative multiply/divide unit implementing the RV32M extension for the micore rv32i core. It sits directly downstream of the register file: it consumes the `reg_out_1`/`reg_out_2` operand pair for an M-type instruction and returns a 32-bit result plus destination tag for the register-file write port. The core stalls on `busy`.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; accepted only when `busy`=0.
- `funct3`  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  32  rs1 value (from reg_out_1).
- `op_b`  in  32  rs2 value (from reg_out_2).
- `rd_in`  in  5  destination register tag.
- `busy`  out  1  high from the cycle after accept until `valid`, inclusive of CALC.
- `valid`  out  1  one-cycle pulse: `result`/`rd_out` are valid; drives register-file `we`.
- `result`  out  32  result; held until next accept.
- `rd_out`  out  5  latched `rd_in`; held until next accept.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: on `start`, latch `funct3`, `rd_in`, operand magnitudes, result sign; load counter=31; go CALC (or DONE directly on fast path).
- CALC: one radix-2 step per cycle. Multiply: shift-add into 64-bit product. Divide: restoring shift-subtract, 32-bit quotient/remainder. Counter 0 -> DONE.
- DONE: apply sign correction (two's-complement negate), select low/high product or quotient/remainder, assert `valid` 1 cycle, go IDLE.
- Signedness: MUL/MULH/DIV/REM both signed; MULHSU `op_a` signed, `op_b` unsigned; MULHU/DIVU/REMU unsigned. Remainder takes sign of dividend.
- Fast path (skip CALC, IDLE -> DONE):
  - divide by zero: quotient 0xFFFFFFFF (DIV and DIVU), remainder = `op_a`.
  - signed overflow DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, REM 0.
- `start` while `busy`=1 or in DONE: ignored, no side effects.
- `rd_in`=0: op executes normally; x0 suppression is the register file's job.

## Timing
- Reset values: `busy`=0, `valid`=0, `result`=0, `rd_out`=0, state IDLE, counter 0.
- `start` accepted at edge N: `busy`=1 from N+1; iterative op `valid`=1 at N+33 (32 CALC cycles + DONE); fast path `valid`=1 at N+1.
- `busy` is 1 in CALC and DONE; 0 in IDLE. A new `start` is accepted in the cycle after `valid` (back-to-back rate one op per 34 cycles).
- `rst` mid-operation: next edge forces IDLE, all outputs to reset values, no `valid` pulse; in-flight op discarded.
- `rst` and `start` same cycle: `rst` wins.

## Configuration
- `MDU_FAST_MUL_EN` defined: MUL/MULH/MULHSU/MULHU use a combinational 33x33 signed multiplier; IDLE -> DONE, `valid` at N+1. Divides unchanged.
- Undefined: all multiplies iterative, `valid` at N+33. Results identical in both builds.

## Test plan
- MUL 7 x 0xFFFFFFFD -> `result`=0xFFFFFFEB, `valid` at N+33 (N+1 with `MDU_FAST_MUL_EN`), `rd_out`=`rd_in`.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF at N+1; REMU -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- Second `start` with different operands at N+5 during CALC -> ignored; first op's result delivered at N+33.
- `rst` at N+10 of a DIV -> at N+11 `busy`=0, `result`=0; no `valid` at N+33; new op then completes correctly.
